fft4_frame_ctrl: RTL and testbench
==================================

Name: fft4_frame_ctrl

Overview:
- Frame sequencer for the 4-point complex FFT datapath (four_fft).
- Collects a stream of complex samples into 4-point frames and holds them stable on the datapath inputs for a programmable settle time.
- Captures the 4 complex results, then streams them out one per handshake.
- Sits between the sample source and the result consumer; the four_fft instance is external and wired to the fft_* ports.

Parameters:
- DW, 4, input sample component width (real and imag each)
- OW, 6, result component width (real and imag each)
- SETTLE_CYCLES, 2, cycles the frame is held on fft_in_* before result capture; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- abort  in  1  synchronous frame discard
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample ready
- s_re  in  DW  input sample real part
- s_im  in  DW  input sample imag part
- fft_in_re  out  4*DW  frame real parts to datapath; slot k at [k*DW +: DW] (slot 0=a, 1=b, 2=c, 3=d)
- fft_in_im  out  4*DW  frame imag parts to datapath, same packing
- fft_out_re  in  4*OW  datapath real results; slot k = A,B,C,D
- fft_out_im  in  4*OW  datapath imag results, same packing
- m_valid  out  1  result valid
- m_ready  in  1  result ready
- m_re  out  OW  result real part
- m_im  out  OW  result imag part
- m_idx  out  2  output bin index of the current result
- m_last  out  1  high with the 4th result of a frame
- busy  out  1  high in SETTLE and DRAIN

Behaviour:
- Reset (async assert, sync deassert by clk):
  - state=FILL, fill count=0, settle count=0, drain count=0
  - sample buffer and result buffer all zero
  - s_ready=1; m_valid, m_last, busy=0; m_re, m_im, m_idx=0
- fft_in_* are driven directly from the sample buffer registers. The sample buffer is written only in FILL, so it is stable throughout SETTLE and DRAIN.
- FILL:
  - s_ready=1.
  - Each s_valid&s_ready writes buffer slot[fill count] and increments the count.
  - The handshake that fills slot 3 sets count=0 and moves to SETTLE.
- SETTLE:
  - s_ready=0, busy=1.
  - Settle count runs 0..SETTLE_CYCLES-1.
  - At the edge ending the last SETTLE cycle, fft_out_re/fft_out_im are latched into the result buffer and state moves to DRAIN.
- DRAIN:
  - m_valid=1, s_ready=0, busy=1.
  - m_re/m_im come from the result buffer slot selected by the output order (see Optional Feature); m_idx is the bin number.
  - Drain count advances only on m_valid&m_ready. m_re/m_im/m_idx hold while m_ready=0.
  - m_last=1 when drain count=3. Its handshake returns to FILL with m_valid dropping the following cycle.
- Latency:
  - The 4th sample is accepted at edge N; results are captured at edge N+SETTLE_CYCLES.
  - m_valid first goes high in the cycle after edge N+SETTLE_CYCLES.
  - Best-case period per frame is 4+SETTLE_CYCLES+4 cycles.
- No overlap between frames: samples offered during SETTLE/DRAIN stall (s_ready=0) and are not lost.
- abort:
  - Has priority over all handshakes in the same cycle.
  - Next state=FILL; all counts=0; m_valid=0 from the next cycle; a handshake in the abort cycle is ignored.
  - Buffers are not cleared; slots are overwritten by later fills.
- Arithmetic: widths are pass-through only. No arithmetic is done on sample or result values.

Optional Feature:
- Macro: FFT4_BITREV_OUT_EN
- Defined: results are emitted in bit-reversed order, slots 0,2,1,3; m_idx carries 0,2,1,3.
- Undefined: natural order, slots 0,1,2,3; m_idx 0,1,2,3.
- m_last is always asserted on the 4th handshake, regardless of order.

Decomposition:
- Shared package fft4_pkg holds:
  - NPTS=4, default DW/OW
  - state enum {FILL, SETTLE, DRAIN}
  - the output-order lookup function mapping drain count to slot (both macro variants)
- One natural sub-module, fft4_out_sel: combinational slot mux taking result buffer and drain count, producing m_re, m_im, m_idx.
- The main FSM, counters and buffers stay in fft4_frame_ctrl.

Test Plan:
- Basic frame:
  - Stimulus: samples (re,im)=(1,0),(2,0),(3,0),(4,0), back-to-back. The datapath stub returns fft_out_re slots 6'h0A,6'h3E,6'h3E,6'h3E and fft_out_im slots 0,6'h02,0,6'h3E. m_ready=1.
  - Required: fft_in_re=16'h4321 during SETTLE; m_valid rises exactly 3 cycles after the 4th handshake (SETTLE_CYCLES=2).
  - Required outputs: m_re 0A,3E,3E,3E; m_im 00,02,00,3E; m_last on the 4th.
- Backpressure:
  - Stimulus: hold m_ready=0 for 5 cycles in DRAIN.
  - Required: m_re/m_idx stable, s_ready=0, no sample accepted despite s_valid=1; draining resumes correctly when m_ready returns.
- Gapped input:
  - Stimulus: s_valid toggles 1,0,1,0 over 8 cycles.
  - Required: exactly 4 samples captured in the correct slots, then SETTLE.
- Abort:
  - Stimulus: abort after 2 samples, then a new frame 5,6,7,8.
  - Required: fft_in_re=16'h8765, no stale output.
  - Stimulus: abort mid-DRAIN at m_idx=1.
  - Required: m_valid=0 next cycle, s_ready=1.
- Reset mid-DRAIN:
  - Stimulus: assert rst_n=0 asynchronously between edges.
  - Required: m_valid=0 and s_ready=1 immediately; all buffers zero.
- FFT4_BITREV_OUT_EN build:
  - Stimulus: rerun the basic frame.
  - Required: m_idx 0,2,1,3 and m_re 0A,3E,3E,3E taken from slots 0,2,1,3.

Source files
------------

// File: rtl/fft4_pkg.sv
// fft4_pkg: shared definitions for the 4-point FFT frame sequencer.
//   NPTS          points per frame
//   DW_DEF/OW_DEF default sample/result component widths
//   state_e       sequencer states
//   out_slot()    maps drain position to result-buffer slot
// Build option: FFT4_BITREV_OUT_EN selects bit-reversed result order
// (slots 0,2,1,3). When it is undefined, results come out in natural order.
package fft4_pkg;

    localparam int NPTS   = 4;
    localparam int DW_DEF = 4;
    localparam int OW_DEF = 6;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SETTLE = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    // Drain position -> result slot (equal to the bin number).
    function automatic logic [1:0] out_slot(input logic [1:0] dcnt);
`ifdef FFT4_BITREV_OUT_EN
        out_slot = {dcnt[0], dcnt[1]};
`else
        out_slot = dcnt;
`endif
    endfunction

endpackage

// File: rtl/fft4_out_sel.sv
// fft4_out_sel: combinational result-slot multiplexer.
//   rbuf_re_i/rbuf_im_i  captured results, slot k = bin k
//   dcnt_i               drain position (0..3)
//   m_re_o/m_im_o        selected result
//   m_idx_o              bin number of the selected result
// Order follows fft4_pkg::out_slot (FFT4_BITREV_OUT_EN aware).
module fft4_out_sel
    import fft4_pkg::*;
#(
    parameter int OW = OW_DEF
) (
    input  logic [NPTS-1:0][OW-1:0] rbuf_re_i,
    input  logic [NPTS-1:0][OW-1:0] rbuf_im_i,
    input  logic [1:0]              dcnt_i,
    output logic [OW-1:0]           m_re_o,
    output logic [OW-1:0]           m_im_o,
    output logic [1:0]              m_idx_o
);

    logic [1:0] slot;

    assign slot    = out_slot(dcnt_i);
    assign m_re_o  = rbuf_re_i[slot];
    assign m_im_o  = rbuf_im_i[slot];
    assign m_idx_o = slot;

endmodule

// File: rtl/fft4_frame_ctrl.sv
// fft4_frame_ctrl: frame sequencer around an external 4-point FFT datapath.
// The block gathers 4 complex samples, holds them on fft_in_* for
// SETTLE_CYCLES cycles, captures fft_out_*, then streams the 4 results out.
//   clk, rst_n          clock, async active-low reset
//   abort               synchronous frame discard (beats all handshakes)
//   s_valid/s_ready     sample input handshake, s_re/s_im sample data
//   fft_in_re/im        frame to datapath, slot k at [k*DW +: DW]
//   fft_out_re/im       datapath results, slot k at [k*OW +: OW]
//   m_valid/m_ready     result handshake, m_re/m_im/m_idx/m_last result
//   busy                high while settling or draining
// Build option: FFT4_BITREV_OUT_EN emits results in order 0,2,1,3.
module fft4_frame_ctrl
    import fft4_pkg::*;
#(
    parameter int DW            = DW_DEF,
    parameter int OW            = OW_DEF,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            abort,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [DW-1:0]   s_re,
    input  logic [DW-1:0]   s_im,
    output logic [4*DW-1:0] fft_in_re,
    output logic [4*DW-1:0] fft_in_im,
    input  logic [4*OW-1:0] fft_out_re,
    input  logic [4*OW-1:0] fft_out_im,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [OW-1:0]   m_re,
    output logic [OW-1:0]   m_im,
    output logic [1:0]      m_idx,
    output logic            m_last,
    output logic            busy
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("fft4_frame_ctrl: SETTLE_CYCLES must be 1..15");
    end

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_e                  state_q;
    logic [1:0]              fcnt_q;
    logic [3:0]              scnt_q;
    logic [1:0]              dcnt_q;
    logic [NPTS-1:0][DW-1:0] sbuf_re_q, sbuf_im_q;
    logic [NPTS-1:0][OW-1:0] rbuf_re_q, rbuf_im_q;
    logic                    s_ready_q, m_valid_q, m_last_q, busy_q;

    // Single sequencer process: state, counters, buffers and the
    // registered handshake/status outputs all move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            fcnt_q    <= '0;
            scnt_q    <= '0;
            dcnt_q    <= '0;
            sbuf_re_q <= '0;
            sbuf_im_q <= '0;
            rbuf_re_q <= '0;
            rbuf_im_q <= '0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else if (abort) begin
            // Buffers are left alone; the next fill overwrites them.
            state_q   <= FILL;
            fcnt_q    <= '0;
            scnt_q    <= '0;
            dcnt_q    <= '0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (s_valid) begin
                        sbuf_re_q[fcnt_q] <= s_re;
                        sbuf_im_q[fcnt_q] <= s_im;
                        if (fcnt_q == 2'd3) begin
                            fcnt_q    <= '0;
                            state_q   <= SETTLE;
                            s_ready_q <= 1'b0;
                            busy_q    <= 1'b1;
                        end else begin
                            fcnt_q <= fcnt_q + 2'd1;
                        end
                    end
                end
                SETTLE: begin
                    if (scnt_q == SETTLE_LAST) begin
                        scnt_q    <= '0;
                        rbuf_re_q <= fft_out_re;
                        rbuf_im_q <= fft_out_im;
                        state_q   <= DRAIN;
                        m_valid_q <= 1'b1;
                    end else begin
                        scnt_q <= scnt_q + 4'd1;
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        if (dcnt_q == 2'd3) begin
                            dcnt_q    <= '0;
                            state_q   <= FILL;
                            s_ready_q <= 1'b1;
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            busy_q    <= 1'b0;
                        end else begin
                            dcnt_q   <= dcnt_q + 2'd1;
                            m_last_q <= (dcnt_q == 2'd2);
                        end
                    end
                end
                default: begin
                    state_q   <= FILL;
                    s_ready_q <= 1'b1;
                    m_valid_q <= 1'b0;
                    m_last_q  <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign busy      = busy_q;
    assign fft_in_re = sbuf_re_q;
    assign fft_in_im = sbuf_im_q;

    fft4_out_sel #(.OW(OW)) u_out_sel (
        .rbuf_re_i (rbuf_re_q),
        .rbuf_im_i (rbuf_im_q),
        .dcnt_i    (dcnt_q),
        .m_re_o    (m_re),
        .m_im_o    (m_im),
        .m_idx_o   (m_idx)
    );

endmodule

// File: tb/tb_fft4_frame_ctrl.sv
module tb_fft4_frame_ctrl;

    localparam int DW = 4;
    localparam int OW = 6;
    localparam int SETTLE = 2;

    logic            clk, rst_n, abort, s_valid, s_ready, m_valid, m_ready;
    logic [DW-1:0]   s_re, s_im;
    logic [4*DW-1:0] fft_in_re, fft_in_im;
    logic [4*OW-1:0] stub_re, stub_im;
    logic [OW-1:0]   m_re, m_im;
    logic [1:0]      m_idx;
    logic            m_last, busy;

    fft4_frame_ctrl #(.DW(DW), .OW(OW), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
        .fft_in_re(fft_in_re), .fft_in_im(fft_in_im),
        .fft_out_re(stub_re), .fft_out_im(stub_im),
        .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im),
        .m_idx(m_idx), .m_last(m_last), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [OW-1:0] re;
        logic [OW-1:0] im;
        logic [1:0]    idx;
        logic          last;
    } res_t;

    res_t                resq[$];
    int                  nacc, settle_left;
    bit                  in_settle;
    logic [3:0][DW-1:0]  md_re, md_im;

    // inputs as seen at each rising edge
    logic            sn_edge = 1'b0, sn_abort, sn_valid, sn_mready;
    logic [DW-1:0]   sn_re, sn_im;
    logic [4*OW-1:0] sn_fre, sn_fim;

    always @(posedge clk) begin
        sn_edge   <= rst_n;
        sn_abort  <= abort;
        sn_valid  <= s_valid;
        sn_mready <= m_ready;
        sn_re     <= s_re;
        sn_im     <= s_im;
        sn_fre    <= stub_re;
        sn_fim    <= stub_im;
    end

    function automatic int bin_at(input int k);
`ifdef FFT4_BITREV_OUT_EN
        return (k == 1) ? 2 : (k == 2) ? 1 : k;
`else
        return k;
`endif
    endfunction

    task automatic mdl_clear();
        nacc = 0; settle_left = 0; in_settle = 0;
        resq.delete();
        md_re = '0; md_im = '0;
    endtask

    task automatic mdl_step();
        res_t r;
        int b;
        if (sn_abort) begin
            nacc = 0; settle_left = 0; in_settle = 0;
            resq.delete();
        end else if (resq.size() != 0) begin
            if (sn_mready) resq.delete(0);
        end else if (in_settle) begin
            settle_left--;
            if (settle_left == 0) begin
                in_settle = 0;
                for (int k = 0; k < 4; k++) begin
                    b      = bin_at(k);
                    r.re   = sn_fre[b*OW +: OW];
                    r.im   = sn_fim[b*OW +: OW];
                    r.idx  = 2'(b);
                    r.last = (k == 3);
                    resq.push_back(r);
                end
            end
        end else if (sn_valid) begin
            md_re[nacc] = sn_re;
            md_im[nacc] = sn_im;
            nacc++;
            if (nacc == 4) begin
                nacc = 0; in_settle = 1; settle_left = SETTLE;
            end
        end
    endtask

    // compare process: every falling edge out of reset
    initial begin
        bit ev;
        mdl_clear();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mdl_clear();
            end else begin
                if (sn_edge) mdl_step();
                ev = (resq.size() != 0);
                chk("s_ready", s_ready, !in_settle && !ev);
                chk("busy", busy, in_settle || ev);
                chk("m_valid", m_valid, ev);
                chk("fft_in_re", fft_in_re, md_re);
                chk("fft_in_im", fft_in_im, md_im);
                chk("m_last", m_last, ev ? resq[0].last : 1'b0);
                if (ev) begin
                    chk("m_re", m_re, resq[0].re);
                    chk("m_im", m_im, resq[0].im);
                    chk("m_idx", m_idx, resq[0].idx);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [OW-1:0] got_re[4], got_im[4];
    logic [1:0]    got_idx[4];
    logic          got_last[4];
    logic [OW-1:0] lit_re[4], lit_im[4];
    logic [1:0]    lit_idx[4];

    // call just after a rising edge
    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im);
        bit r;
        s_valid = 1'b1; s_re = re; s_im = im;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); r = s_ready;
            @(posedge clk); #1;
            if (r) begin
                s_valid = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        chk("send_timeout", 0, 1);
    endtask

    task automatic send4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c, input logic [DW-1:0] d);
        send(a, a); send(b, b); send(c, c); send(d, d);
    endtask

    // returns at a falling edge with m_valid high; lat = falling edges waited
    task automatic wait_mvalid(output int lat);
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); lat++;
            if (m_valid) return;
        end
        chk("mvalid_timeout", 0, 1);
    endtask

    // call just after a rising edge; drains one frame with m_ready=1
    task automatic collect();
        int n = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (m_valid) begin
                got_re[n] = m_re; got_im[n] = m_im;
                got_idx[n] = m_idx; got_last[n] = m_last;
                n++;
            end
        end
        @(posedge clk); #1;
        chk("collect_count", n, 4);
    endtask

    initial begin
        int lat;
        bit seen1;
        rst_n = 1'b0; abort = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        s_re = '0; s_im = '0;
        stub_re = {6'h3E, 6'h3E, 6'h3E, 6'h0A};
        stub_im = {6'h3E, 6'h00, 6'h02, 6'h00};
        lit_re = '{6'h0A, 6'h3E, 6'h3E, 6'h3E};
`ifdef FFT4_BITREV_OUT_EN
        lit_im  = '{6'h00, 6'h00, 6'h02, 6'h3E};
        lit_idx = '{2'd0, 2'd2, 2'd1, 2'd3};
`else
        lit_im  = '{6'h00, 6'h02, 6'h00, 6'h3E};
        lit_idx = '{2'd0, 2'd1, 2'd2, 2'd3};
`endif

        // reset values
        #12;
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_m_idx", m_idx, 2'd0);
        chk("rst_fft_in_re", fft_in_re, 16'h0000);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        // basic frame: (1,0),(2,0),(3,0),(4,0)
        send(4'd1, 4'd0); send(4'd2, 4'd0); send(4'd3, 4'd0); send(4'd4, 4'd0);
        @(negedge clk);
        chk("basic_fft_in_re", fft_in_re, 16'h4321);
        chk("basic_fft_in_im", fft_in_im, 16'h0000);
        chk("basic_busy", busy, 1'b1);
        wait_mvalid(lat);
        chk("basic_latency", lat + 1, 3);
        @(posedge clk); #1;
        collect();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("basic_re%0d", k), got_re[k], lit_re[k]);
            chk($sformatf("basic_im%0d", k), got_im[k], lit_im[k]);
            chk($sformatf("basic_idx%0d", k), got_idx[k], lit_idx[k]);
            chk($sformatf("basic_last%0d", k), got_last[k], k == 3);
        end

        // backpressure: stall 5 cycles in DRAIN while a sample is offered
        m_ready = 1'b0;
        send4(4'd9, 4'd10, 4'd11, 4'd12);
        wait_mvalid(lat);
        @(posedge clk); #1;
        s_valid = 1'b1; s_re = 4'd5; s_im = 4'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_s_ready", s_ready, 1'b0);
            chk("bp_m_idx", m_idx, 2'd0);
            chk("bp_m_re", m_re, 6'h0A);
            chk("bp_m_valid", m_valid, 1'b1);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        chk("bp_fft_in_re", fft_in_re, 16'hCBA9);
        collect();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp_re%0d", k), got_re[k], lit_re[k]);
            chk($sformatf("bp_idx%0d", k), got_idx[k], lit_idx[k]);
        end

        // gapped input: valid 1,0,1,0,... over 8 cycles
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_valid = (i % 2 == 0);
            s_re = 4'(i / 2 + 1); s_im = 4'(i / 2 + 1);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        @(negedge clk);
        chk("gap_busy", busy, 1'b1);
        chk("gap_fft_in_re", fft_in_re, 16'h4321);
        chk("gap_fft_in_im", fft_in_im, 16'h4321);
        @(posedge clk); #1;
        collect();
        chk("gap_last3", got_last[3], 1'b1);

        // abort after two samples (abort-cycle handshake ignored), then 5,6,7,8
        stub_re = {6'h11, 6'h22, 6'h33, 6'h04};
        stub_im = {6'h15, 6'h25, 6'h35, 6'h05};
        m_ready = 1'b0;
        send(4'd9, 4'd9); send(4'd9, 4'd9);
        abort = 1'b1; s_valid = 1'b1; s_re = 4'hF; s_im = 4'hF;
        @(posedge clk); #1;
        abort = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        chk("ab_s_ready", s_ready, 1'b1);
        chk("ab_m_valid", m_valid, 1'b0);
        @(posedge clk); #1;
        send4(4'd5, 4'd6, 4'd7, 4'd8);
        @(negedge clk);
        chk("ab_fft_in_re", fft_in_re, 16'h8765);
        @(posedge clk); #1;
        collect();
        chk("ab_re0", got_re[0], 6'h04);
        chk("ab_re3", got_re[3], 6'h11);
        chk("ab_im0", got_im[0], 6'h05);

        // abort mid-DRAIN at m_idx=1
        m_ready = 1'b0;
        send4(4'd1, 4'd2, 4'd3, 4'd4);
        wait_mvalid(lat);
        m_ready = 1'b1;
        seen1 = 1'b0;
        for (int i = 0; i < 10 && !seen1; i++) begin
            if (m_valid && m_idx == 2'd1) seen1 = 1'b1;
            else @(negedge clk);
        end
        chk("mid_seen_idx1", seen1, 1'b1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        chk("mid_m_valid", m_valid, 1'b0);
        chk("mid_s_ready", s_ready, 1'b1);
        chk("mid_busy", busy, 1'b0);
        @(posedge clk); #1;

        // asynchronous reset mid-DRAIN
        send4(4'd3, 4'd4, 4'd5, 4'd6);
        wait_mvalid(lat);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_m_valid", m_valid, 1'b0);
        chk("arst_s_ready", s_ready, 1'b1);
        chk("arst_busy", busy, 1'b0);
        chk("arst_fft_in_re", fft_in_re, 16'h0000);
        chk("arst_fft_in_im", fft_in_im, 16'h0000);
        chk("arst_m_re", m_re, 6'h00);
        chk("arst_m_im", m_im, 6'h00);
        @(negedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // recovery frame after reset
        stub_re = {6'h3E, 6'h3E, 6'h3E, 6'h0A};
        stub_im = {6'h3E, 6'h00, 6'h02, 6'h00};
        send4(4'd1, 4'd2, 4'd3, 4'd4);
        collect();
        for (int k = 0; k < 4; k++)
            chk($sformatf("rec_im%0d", k), got_im[k], lit_im[k]);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
